// File: rtl/final2_soc_pio_ext.sv
// Avalon-MM parallel I/O port with set/clear strobes and optional edge IRQ.
// Define PIO_EXT_EDGE_IRQ_EN to build the edge capture / interrupt logic.
module final2_soc_pio_ext #(
   parameter int                 DATA_W    = 16,
   parameter logic [DATA_W-1:0]  RESET_VAL = '0
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [2:0]        address,
   input  logic              chipselect,
   input  logic              write_n,
   input  logic [31:0]       writedata,
   output logic [31:0]       readdata,
   input  logic [DATA_W-1:0] in_port,
   output logic [DATA_W-1:0] out_port,
   output logic [DATA_W-1:0] out_oe,
   output logic              irq
);

   logic [DATA_W-1:0] r_sync1;
   logic [DATA_W-1:0] r_sync2;
   logic [DATA_W-1:0] r_out;
   logic [DATA_W-1:0] r_dir;
   logic [DATA_W-1:0] w_wd;
   logic [DATA_W-1:0] w_rd;
   logic [31:0]       w_rd32;
   logic              w_wr;
   logic              w_unused;

   assign w_wr     = chipselect & ~write_n;
   assign w_wd     = writedata[DATA_W-1:0];
   assign w_unused = ^writedata;
   assign out_port = r_out;
   assign out_oe   = r_dir;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
         r_out   <= RESET_VAL;
         r_dir   <= '0;
      end else begin
         r_sync1 <= in_port;
         r_sync2 <= r_sync1;
         if (w_wr) begin
            case (address)
               3'd0:    r_out <= w_wd;
               3'd1:    r_dir <= w_wd;
               3'd4:    r_out <= r_out | w_wd;
               3'd5:    r_out <= r_out & ~w_wd;
               default: ;
            endcase
         end
      end
   end

`ifdef PIO_EXT_EDGE_IRQ_EN
   logic [DATA_W-1:0] r_prev;
   logic [DATA_W-1:0] r_mask;
   logic [DATA_W-1:0] r_cap;
   logic [1:0]        r_arm;
   logic [DATA_W-1:0] w_edge;
   logic [DATA_W-1:0] w_clr;

   // Edges are ignored until the synchroniser has flushed post-reset state.
   assign w_edge = (r_arm == 2'd3) ? (r_sync2 & ~r_prev) : '0;
   assign w_clr  = (w_wr && address == 3'd3) ? w_wd : '0;
   assign irq    = |(r_cap & r_mask);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_prev <= '0;
         r_mask <= '0;
         r_cap  <= '0;
         r_arm  <= '0;
      end else begin
         r_prev <= r_sync2;
         if (r_arm != 2'd3)
            r_arm <= r_arm + 2'd1;
         if (w_wr && address == 3'd2)
            r_mask <= w_wd;
         r_cap <= (r_cap & ~w_clr) | w_edge;
      end
   end
`else
   assign irq = 1'b0;
`endif

   always_comb begin
      w_rd = '0;
      case (address)
         3'd0:    w_rd = r_sync2;
         3'd1:    w_rd = r_dir;
`ifdef PIO_EXT_EDGE_IRQ_EN
         3'd2:    w_rd = r_mask;
         3'd3:    w_rd = r_cap;
`endif
         default: w_rd = '0;
      endcase
   end

   always_comb begin
      w_rd32             = '0;
      w_rd32[DATA_W-1:0] = w_rd;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         readdata <= '0;
      else
         readdata <= w_rd32;
   end

endmodule

// File: tb/tb_final2_soc_pio_ext.sv
// Directed self-checking bench for final2_soc_pio_ext (DATA_W=16).
// Edge/IRQ vectors run only when PIO_EXT_EDGE_IRQ_EN is defined.
module tb_final2_soc_pio_ext;

   localparam int          DW   = 16;
   localparam logic [15:0] RSTV = 16'hC3C3;

   logic          clk = 1'b0;
   logic          reset_n;
   logic [2:0]    address;
   logic          chipselect;
   logic          write_n;
   logic [31:0]   writedata;
   logic [31:0]   readdata;
   logic [DW-1:0] in_port;
   logic [DW-1:0] out_port;
   logic [DW-1:0] out_oe;
   logic          irq;

   int n_cmp = 0;
   int n_err = 0;

   final2_soc_pio_ext #(.DATA_W(DW), .RESET_VAL(RSTV)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .in_port    (in_port),
      .out_port   (out_port),
      .out_oe     (out_oe),
      .irq        (irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      cyc(1);
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   task automatic rd(input string tag, input logic [2:0] a,
                     input logic [31:0] exp);
      address = a;
      cyc(1);
      check(tag, readdata, exp);
   endtask

   initial begin
      reset_n    = 1'b0;
      address    = 3'd0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;
      in_port    = '0;
      #12;
      check("rst_out", {16'h0, out_port}, {16'h0, RSTV});
      check("rst_oe", {16'h0, out_oe}, 32'h0);
      check("rst_rd", readdata, 32'h0);
      check("rst_irq", {31'h0, irq}, 32'h0);
      #3 reset_n = 1'b1;
      cyc(1);

      // set / clear strobes on successive cycles
      wr(3'd0, 32'h0000_1234);
      check("out_wr", {16'h0, out_port}, 32'h1234);
      wr(3'd4, 32'h0000_00F0);
      check("out_set", {16'h0, out_port}, 32'h12F4);
      wr(3'd5, 32'h0000_0004);
      check("out_clr", {16'h0, out_port}, 32'h12F0);
      wr(3'd0, 32'hABCD_5678);
      check("out_hi", {16'h0, out_port}, 32'h5678);

      address   = 3'd0;
      writedata = 32'h0000_FFFF;
      write_n   = 1'b0;
      cyc(1);
      write_n   = 1'b1;
      check("cs_off", {16'h0, out_port}, 32'h5678);

      wr(3'd1, 32'hFFFF_00FF);
      check("dir_oe", {16'h0, out_oe}, 32'h00FF);
      rd("dir_rd", 3'd1, 32'h0000_00FF);
      rd("data_nodir", 3'd0, 32'h0);

      wr(3'd6, 32'h0000_FFFF);
      wr(3'd7, 32'h0000_0000);
      check("resv_wr", {16'h0, out_port}, 32'h5678);
      rd("rd4", 3'd4, 32'h0);
      rd("rd5", 3'd5, 32'h0);
      rd("rd6", 3'd6, 32'h0);

      // input latency: 2 sync flops + registered read
      address = 3'd0;
      in_port = 16'hA5A5;
      cyc(2);
      check("lat2", readdata, 32'h0);
      cyc(1);
      check("lat3", readdata, 32'h0000_A5A5);

      // reset in the middle of a write; input held high through release
      address    = 3'd0;
      writedata  = 32'h0000_7777;
      chipselect = 1'b1;
      write_n    = 1'b0;
      in_port    = 16'hFFFF;
      #2 reset_n = 1'b0;
      #1;
      check("mid_out", {16'h0, out_port}, {16'h0, RSTV});
      check("mid_rd", readdata, 32'h0);
      check("mid_oe", {16'h0, out_oe}, 32'h0);
      chipselect = 1'b0;
      write_n    = 1'b1;
      cyc(2);
      check("mid_hold", {16'h0, out_port}, {16'h0, RSTV});
      #3 reset_n = 1'b1;
      address = 3'd0;
      cyc(1);
      check("sync_rst", readdata, 32'h0);
      cyc(3);
      check("sync_ff", readdata, 32'h0000_FFFF);

`ifdef PIO_EXT_EDGE_IRQ_EN
      cyc(3);
      rd("arm_cap", 3'd3, 32'h0);
      check("arm_irq", {31'h0, irq}, 32'h0);
      rd("mask_rst", 3'd2, 32'h0);

      in_port = 16'h0000;
      cyc(3);
      wr(3'd2, 32'h0000_0001);
      rd("mask_rd", 3'd2, 32'h0000_0001);
      in_port = 16'h0001;
      cyc(2);
      check("irq_e2", {31'h0, irq}, 32'h0);
      cyc(1);
      check("irq_e3", {31'h0, irq}, 32'h1);
      rd("cap_set", 3'd3, 32'h0000_0001);
      wr(3'd3, 32'h0000_0001);
      check("w1c_irq", {31'h0, irq}, 32'h0);
      rd("w1c_cap", 3'd3, 32'h0);

      // edge arriving on the same edge as its clear
      in_port = 16'h0000;
      cyc(3);
      in_port = 16'h0001;
      cyc(2);
      wr(3'd3, 32'h0000_0001);
      check("race_irq", {31'h0, irq}, 32'h1);
      rd("race_cap", 3'd3, 32'h0000_0001);

      wr(3'd2, 32'h0000_0000);
      check("mask_off", {31'h0, irq}, 32'h0);
      rd("mask_cap", 3'd3, 32'h0000_0001);

      wr(3'd3, 32'h0000_FFFF);
      in_port = 16'h0000;
      cyc(4);
      rd("fall_cap", 3'd3, 32'h0);

      wr(3'd2, 32'h0000_FFFF);
      in_port = 16'h00F0;
      cyc(3);
      rd("multi_cap", 3'd3, 32'h0000_00F0);
      check("multi_irq", {31'h0, irq}, 32'h1);
`else
      in_port = 16'h0000;
      cyc(4);
      in_port = 16'h5A5A;
      cyc(4);
      wr(3'd2, 32'h0000_FFFF);
      wr(3'd3, 32'h0000_FFFF);
      rd("off_rd2", 3'd2, 32'h0);
      rd("off_rd3", 3'd3, 32'h0);
      check("off_irq", {31'h0, irq}, 32'h0);
      rd("off_data", 3'd0, 32'h0000_5A5A);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
